// File: rtl/fp_apb_pkg.sv
// Shared definitions for the queued FP multiplier: register offsets,
// STATUS/CTRL bit positions, engine state encoding and APB response codes.
package fp_apb_pkg;

  localparam logic [2:0] REG_OPA    = 3'd0;
  localparam logic [2:0] REG_OPB    = 3'd1;
  localparam logic [2:0] REG_RESULT = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_JOB_FULL  = 1;
  localparam int STAT_JOB_EMPTY = 2;
  localparam int STAT_RES_FULL  = 3;
  localparam int STAT_RES_EMPTY = 4;
  localparam int STAT_OVF       = 5;
  localparam int STAT_UDF       = 6;
  localparam int STAT_TMO       = 7;
  localparam int STAT_JCNT      = 8;
  localparam int STAT_RCNT      = 16;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  typedef enum logic [1:0] {
    ENG_IDLE    = 2'd0,
    ENG_ISSUE   = 2'd1,
    ENG_RELEASE = 2'd2
  } eng_state_e;

endpackage

// File: rtl/fp_mul_apb_queue_if.sv
// APB bus bundle between the platform master and the queued FP multiplier.
interface fp_mul_apb_queue_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (output paddr, psel, penable, pwrite, pwdata,
                  input  pready, prdata, pslverr);
  modport slave  (input  paddr, psel, penable, pwrite, pwdata,
                  output pready, prdata, pslverr);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; flush overrides any same-cycle push/pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/verilog_multiplier.sv
// Multi-cycle single-precision multiplier core: computes while ready is high,
// raises done with res after a fixed latency, drops done when ready falls.
module verilog_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic        done,
  output logic [31:0] res
);

  logic [47:0] prod;
  logic        sgn;
  logic        norm;
  logic [22:0] frac;
  logic        guard;
  logic        sticky;
  logic        rnd;
  logic [23:0] frac_r;
  logic [9:0]  esum;
  logic [31:0] res_c;
  logic [1:0]  lat;

  // denormals flush to zero, NaN collapses to infinity, round to nearest even
  always_comb begin
    sgn  = op1[31] ^ op2[31];
    prod = {24'b0, 1'b1, op1[22:0]} * {24'b0, 1'b1, op2[22:0]};
    norm = prod[47];
    if (norm) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    rnd    = guard & (sticky | frac[0]);
    frac_r = {1'b0, frac} + {23'b0, rnd};
    esum   = {2'b0, op1[30:23]} + {2'b0, op2[30:23]} + {9'b0, norm} + {9'b0, frac_r[23]};
    if (op1[30:23] == 8'h00 || op2[30:23] == 8'h00)
      res_c = {sgn, 31'b0};
    else if (op1[30:23] == 8'hFF || op2[30:23] == 8'hFF || esum >= 10'd382)
      res_c = {sgn, 8'hFF, 23'b0};
    else if (esum <= 10'd127)
      res_c = {sgn, 31'b0};
    else
      res_c = {sgn, 8'(esum - 10'd127), frac_r[22:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      res  <= '0;
      lat  <= '0;
    end else if (!ready) begin
      done <= 1'b0;
      lat  <= '0;
    end else if (!done) begin
      if (lat == 2'd2) begin
        done <= 1'b1;
        res  <= res_c;
      end else begin
        lat <= lat + 2'd1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_apb_queue.sv
// APB register file feeding a job FIFO, an engine that drives the multiplier
// core one job at a time, and a result FIFO read back through RESULT.
//
// state   | meaning
// IDLE    | waiting for a queued job and room in the result FIFO
// ISSUE   | core ready high, operands held, waiting for done or timeout
// RELEASE | ready low for one cycle so the core sees it fall between jobs
module fp_mul_apb_queue
  import fp_apb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] BASE_MASK   = 32'h0000_001C
) (
  input  logic              pclk,
  input  logic              presetn,
  fp_mul_apb_queue_if.slave apb,
  output logic              irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);

  logic [31:0]   addr_m;
  logic [2:0]    off;
  logic          access;
  logic          unused_addr;
  logic [31:0]   prdata_c;
  logic          pslverr_c;

  logic [31:0]   opa_q;
  logic          ovf_q, udf_q, tmo_q;
  logic          opa_we, job_push, res_pop;
  logic          ovf_set, udf_set, tmo_set;
  logic          ctrl_flush, sticky_clr;
  logic [31:0]   status;

  logic [63:0]   job_head;
  logic          job_full, job_empty, job_pop;
  logic [CW-1:0] job_cnt;
  logic [31:0]   res_head;
  logic          res_full, res_empty, res_push;
  logic [CW-1:0] res_cnt;

  eng_state_e    state, state_nxt;
  logic [63:0]   op_q;
  logic [TW-1:0] tmr;
  logic          core_kill, core_rst_q, core_rst;
  logic          core_ready, core_done;
  logic [31:0]   core_res;
  logic          busy;

  assign addr_m      = apb.paddr & BASE_MASK;
  assign off         = addr_m[4:2];
  assign unused_addr = ^{addr_m[31:5], addr_m[1:0]};
  assign access      = apb.psel & apb.penable;
  assign apb.pready  = access;
  assign apb.prdata  = prdata_c;
  assign apb.pslverr = pslverr_c;
  assign busy        = (state != ENG_IDLE);
  assign irq         = ~res_empty | ovf_q | udf_q | tmo_q;

  always_comb begin
    status                      = '0;
    status[STAT_BUSY]           = busy;
    status[STAT_JOB_FULL]       = job_full;
    status[STAT_JOB_EMPTY]      = job_empty;
    status[STAT_RES_FULL]       = res_full;
    status[STAT_RES_EMPTY]      = res_empty;
    status[STAT_OVF]            = ovf_q;
    status[STAT_UDF]            = udf_q;
    status[STAT_TMO]            = tmo_q;
    status[STAT_JCNT +: 8]      = 8'(job_cnt);
    status[STAT_RCNT +: 8]      = 8'(res_cnt);
  end

  always_comb begin
    prdata_c   = '0;
    pslverr_c  = RESP_OK;
    opa_we     = 1'b0;
    job_push   = 1'b0;
    res_pop    = 1'b0;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    ctrl_flush = 1'b0;
    sticky_clr = 1'b0;
    if (access) begin
      case (off)
        REG_OPA: begin
          if (apb.pwrite) opa_we = 1'b1;
          else            prdata_c = opa_q;
        end
        REG_OPB: begin
          if (apb.pwrite) begin
            if (job_full) begin
              pslverr_c = RESP_ERR;
              ovf_set   = 1'b1;
            end else begin
              job_push = 1'b1;
            end
          end
        end
        REG_RESULT: begin
          if (apb.pwrite) begin
            pslverr_c = RESP_ERR;
          end else if (res_empty) begin
            pslverr_c = RESP_ERR;
            udf_set   = 1'b1;
          end else begin
            prdata_c = res_head;
            res_pop  = 1'b1;
          end
        end
        REG_STATUS: begin
          if (apb.pwrite) pslverr_c = RESP_ERR;
          else            prdata_c  = status;
        end
        REG_CTRL: begin
          if (apb.pwrite) begin
            ctrl_flush = apb.pwdata[CTRL_FLUSH];
            sticky_clr = apb.pwdata[CTRL_CLR];
          end
        end
        default: pslverr_c = RESP_ERR;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (presetn) begin
      opa_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      if (opa_we) opa_q <= apb.pwdata;
      ovf_q <= ovf_set | (ovf_q & ~sticky_clr);
      udf_q <= udf_set | (udf_q & ~sticky_clr);
      tmo_q <= tmo_set | (tmo_q & ~sticky_clr);
    end
  end

  sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_job_fifo (
    .clk   (pclk),
    .rst   (presetn),
    .flush (ctrl_flush),
    .push  (job_push),
    .wdata ({opa_q, apb.pwdata}),
    .pop   (job_pop),
    .rdata (job_head),
    .full  (job_full),
    .empty (job_empty),
    .count (job_cnt)
  );

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_res_fifo (
    .clk   (pclk),
    .rst   (presetn),
    .flush (ctrl_flush),
    .push  (res_push),
    .wdata (core_res),
    .pop   (res_pop),
    .rdata (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_cnt)
  );

  always_ff @(posedge pclk) begin
    if (presetn) begin
      state      <= ENG_IDLE;
      op_q       <= '0;
      tmr        <= TMR_LOAD;
      core_rst_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      core_rst_q <= core_kill;
      if (job_pop) op_q <= job_head;
      if (state != ENG_ISSUE) tmr <= TMR_LOAD;
      else if (tmr != '0)     tmr <= tmr - TW'(1);
    end
  end

  // result space is reserved at IDLE, so the push on done never meets a full FIFO
  always_comb begin
    state_nxt  = state;
    job_pop    = 1'b0;
    res_push   = 1'b0;
    tmo_set    = 1'b0;
    core_kill  = 1'b0;
    core_ready = 1'b0;
    case (state)
      ENG_IDLE: begin
        if (!ctrl_flush && !job_empty && !res_full) begin
          job_pop   = 1'b1;
          state_nxt = ENG_ISSUE;
        end
      end
      ENG_ISSUE: begin
        core_ready = 1'b1;
        if (ctrl_flush) begin
          core_kill = 1'b1;
          state_nxt = ENG_RELEASE;
        end else if (core_done) begin
          res_push  = 1'b1;
          state_nxt = ENG_RELEASE;
        end else if (tmr == '0) begin
          tmo_set   = 1'b1;
          core_kill = 1'b1;
          state_nxt = ENG_RELEASE;
        end
      end
      ENG_RELEASE: state_nxt = ENG_IDLE;
      default:     state_nxt = ENG_IDLE;
    endcase
  end

  assign core_rst = presetn | core_rst_q;

  verilog_multiplier u_core (
    .clk   (pclk),
    .rst   (core_rst),
    .ready (core_ready),
    .op1   (op_q[63:32]),
    .op2   (op_q[31:0]),
    .done  (core_done),
    .res   (core_res)
  );

endmodule

// File: tb/tb_fp_mul_apb_queue.sv
// Directed bench for the queued FP multiplier: register map, ordering,
// overflow/underflow, timeout, flush and mid-job reset.
module tb_fp_mul_apb_queue;

  localparam logic [31:0] A_OPA  = 32'h00;
  localparam logic [31:0] A_OPB  = 32'h04;
  localparam logic [31:0] A_RES  = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C;
  localparam logic [31:0] A_CTRL = 32'h10;

  logic pclk    = 1'b0;
  logic presetn = 1'b1;
  logic irq;
  int   vec_cnt  = 0;
  int   miss_cnt = 0;

  logic [31:0] ja [4] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4040_0000, 32'h4080_0000};
  logic [31:0] jb [4] = '{32'h3F80_0000, 32'hC000_0000, 32'h4040_0000, 32'h3F00_0000};
  logic [31:0] jr [4] = '{32'h3F80_0000, 32'hC040_0000, 32'h4110_0000, 32'h4000_0000};

  fp_mul_apb_queue_if bus ();

  fp_mul_apb_queue #(
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (16),
    .BASE_MASK   (32'h0000_001C)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (bus),
    .irq     (irq)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // each access starts #1 after a rising edge and returns #1 after its access edge
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    bus.paddr = a; bus.pwdata = d; bus.pwrite = 1'b1; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge pclk); #1 bus.penable = 1'b1;
    @(negedge pclk); err = bus.pslverr;
    @(posedge pclk); #1 bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    bus.paddr = a; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge pclk); #1 bus.penable = 1'b1;
    @(negedge pclk); d = bus.prdata; err = bus.pslverr;
    @(posedge pclk); #1 bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic push_job(input logic [31:0] a, input logic [31:0] b, output logic err);
    logic unused_e;
    apb_write(A_OPA, a, unused_e);
    apb_write(A_OPB, b, err);
  endtask

  task automatic wait_rcnt(input logic [7:0] n);
    logic [31:0] st;
    logic        unused_e;
    st = '0;
    for (int i = 0; i < 60; i++) begin
      apb_read(A_STAT, st, unused_e);
      if (st[23:16] == n) break;
    end
    chk("poll_rcnt", {24'b0, st[23:16]}, {24'b0, n});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          n;

    bus.paddr = '0; bus.pwdata = '0; bus.pwrite = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b0;
    @(negedge pclk);
    chk("rst_irq",    {31'b0, irq},        32'h0);
    chk("idle_pready",{31'b0, bus.pready}, 32'h0);
    chk("idle_prdata", bus.prdata,         32'h0);
    @(posedge pclk); #1;
    apb_read(A_STAT, rd, e); chk("rst_status", rd, 32'h0000_0014);
    apb_read(A_OPA,  rd, e); chk("rst_opa",    rd, 32'h0);

    // single job, 2.0 * 3.0
    push_job(32'h4000_0000, 32'h4040_0000, e);
    chk("t1_push_err", {31'b0, e}, 32'h0);
    wait_rcnt(8'd1);
    chk("t1_irq_high", {31'b0, irq}, 32'h1);
    apb_read(A_RES, rd, e);
    chk("t1_result", rd, 32'h40C0_0000);
    chk("t1_err",    {31'b0, e}, 32'h0);
    chk("t1_irq_fall", {31'b0, irq}, 32'h0);

    // decode: upper address bits ignored, bad accesses flagged
    apb_write(32'hABC0_0000, 32'h1234_5678, e);
    apb_read(A_OPA, rd, e);  chk("opa_alias", rd, 32'h1234_5678);
    apb_read(A_OPB, rd, e);  chk("opb_read", rd, 32'h0);
    chk("opb_read_err", {31'b0, e}, 32'h0);
    apb_write(A_STAT, 32'hFFFF_FFFF, e); chk("stat_wr_err", {31'b0, e}, 32'h1);
    apb_write(A_RES,  32'h0, e);         chk("res_wr_err",  {31'b0, e}, 32'h1);
    apb_read(32'h14, rd, e);
    chk("bad_off_data", rd, 32'h0);
    chk("bad_off_err", {31'b0, e}, 32'h1);

    // four queued jobs come back in order
    for (int i = 0; i < 4; i++) push_job(ja[i], jb[i], e);
    wait_rcnt(8'd4);
    for (int i = 0; i < 4; i++) begin
      apb_read(A_STAT, rd, e);
      chk($sformatf("t2_rcnt%0d", i), {24'b0, rd[23:16]}, 32'(4 - i));
      apb_read(A_RES, rd, e);
      chk($sformatf("t2_res%0d", i), rd, jr[i]);
    end
    apb_read(A_STAT, rd, e);
    chk("t2_rcnt_end", {24'b0, rd[23:16]}, 32'h0);

    // stall the engine on a full result FIFO, then overflow the job FIFO
    for (int i = 0; i < 4; i++) push_job(ja[i], jb[i], e);
    wait_rcnt(8'd4);
    for (int i = 0; i < 4; i++) apb_write(A_OPB, 32'h3F80_0000, e);
    apb_write(A_OPB, 32'h3F80_0000, e);
    chk("t3_ovf_err", {31'b0, e}, 32'h1);
    apb_read(A_STAT, rd, e);
    chk("t3_status", rd, 32'h0004_042A);
    chk("t3_irq", {31'b0, irq}, 32'h1);

    // flush, underflow, sticky clear
    apb_write(A_CTRL, 32'h1, e);
    apb_read(A_RES, rd, e);
    chk("t4_udf_data", rd, 32'h0);
    chk("t4_udf_err", {31'b0, e}, 32'h1);
    apb_read(A_STAT, rd, e);
    chk("t4_status", rd, 32'h0000_0074);
    apb_write(A_CTRL, 32'h2, e);
    apb_read(A_STAT, rd, e);
    chk("t4_cleared", rd, 32'h0000_0014);

    // core withholds done: timeout 16 cycles after ISSUE entry
    force dut.core_done = 1'b0;
    push_job(32'h4000_0000, 32'h4000_0000, e);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if (dut.core_ready) break;
    end
    chk("t5_ready", {31'b0, dut.core_ready}, 32'h1);
    for (int i = 0; i < 40; i++) begin
      @(negedge pclk);
      n++;
      if (irq) break;
    end
    chk("t5_tmo_cycles", n, 32'd16);
    @(posedge pclk); #1;
    release dut.core_done;
    apb_read(A_STAT, rd, e);
    chk("t5_status", rd, 32'h0000_0094);
    push_job(32'h4000_0000, 32'h4040_0000, e);
    wait_rcnt(8'd1);
    apb_read(A_RES, rd, e);
    chk("t5_next_res", rd, 32'h40C0_0000);
    apb_write(A_CTRL, 32'h2, e);

    // flush during ISSUE with three jobs queued behind it
    force dut.core_done = 1'b0;
    apb_write(A_OPA, 32'h4040_0000, e);
    for (int i = 0; i < 4; i++) apb_write(A_OPB, 32'h4040_0000, e);
    apb_read(A_STAT, rd, e);
    chk("t6_pre_flush", rd, 32'h0000_0311);
    apb_write(A_CTRL, 32'h1, e);
    apb_read(A_STAT, rd, e);
    chk("t6_post_flush", rd, 32'h0000_0014);
    release dut.core_done;
    push_job(32'h4000_0000, 32'h4040_0000, e);
    wait_rcnt(8'd1);
    apb_read(A_RES, rd, e);
    chk("t6_after_res", rd, 32'h40C0_0000);

    // reset in the middle of a job
    force dut.core_done = 1'b0;
    push_job(32'h3FC0_0000, 32'hC000_0000, e);
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b0;
    release dut.core_done;
    @(negedge pclk);
    chk("t7_irq", {31'b0, irq}, 32'h0);
    @(posedge pclk); #1;
    apb_read(A_STAT, rd, e);
    chk("t7_status", rd, 32'h0000_0014);
    apb_read(A_OPA, rd, e);
    chk("t7_opa", rd, 32'h0);
    push_job(32'h3FC0_0000, 32'hC000_0000, e);
    wait_rcnt(8'd1);
    apb_read(A_RES, rd, e);
    chk("t7_res", rd, 32'hC040_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
